// File: rtl/apb_uart_host.sv
// APB master that configures a 16550-style UART, then polls LSR to move bytes; each transfer is SETUP+ACCESS+one IDLE cycle.
// TX handshake completes on THR write ACCESS; RX holds one byte until rx_ready_i; PREADY low stalls everything.
module apb_uart_host #(
    parameter int          APB_ADDR_WIDTH = 12,
    parameter logic [15:0] DIVISOR        = 16'd27,
    parameter logic [7:0]  LCR_CFG        = 8'h03
) (
    input  logic                      CLK,
    input  logic                      RST,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR,
    input  logic [7:0]                tx_data_i,
    input  logic                      tx_valid_i,
    output logic                      tx_ready_o,
    output logic [7:0]                rx_data_o,
    output logic                      rx_perr_o,
    output logic                      rx_valid_o,
    input  logic                      rx_ready_i,
    output logic                      init_done_o,
    output logic                      apb_err_o
);

    localparam logic [2:0] OP_LCR_DLAB = 3'd0;
    localparam logic [2:0] OP_DLL      = 3'd1;
    localparam logic [2:0] OP_DLM      = 3'd2;
    localparam logic [2:0] OP_LCR      = 3'd3;
    localparam logic [2:0] OP_FCR      = 3'd4;
    localparam logic [2:0] OP_LSR      = 3'd5;
    localparam logic [2:0] OP_RBR      = 3'd6;
    localparam logic [2:0] OP_THR      = 3'd7;

    localparam logic [2:0] REG_RBR = 3'd0;
    localparam logic [2:0] REG_DLM = 3'd1;
    localparam logic [2:0] REG_FCR = 3'd2;
    localparam logic [2:0] REG_LCR = 3'd3;
    localparam logic [2:0] REG_LSR = 3'd5;

    logic [2:0] op;
    logic [2:0] next_op;
    logic       lsr_perr;
    logic [2:0] idx;
    logic       wr;
    logic [7:0] wdat;
    logic       done;
    logic       unused_prdata;

    assign unused_prdata = ^PRDATA[31:8];
    assign done          = PSEL & PENABLE & PREADY;
    assign tx_ready_o    = done && (op == OP_THR);

    // Address/data for the transfer about to be launched from IDLE.
    always_comb begin
        idx  = REG_LSR;
        wr   = 1'b0;
        wdat = 8'h00;
        case (next_op)
            OP_LCR_DLAB: begin idx = REG_LCR; wr = 1'b1; wdat = 8'h80;                 end
            OP_DLL:      begin idx = REG_RBR; wr = 1'b1; wdat = DIVISOR[7:0];          end
            OP_DLM:      begin idx = REG_DLM; wr = 1'b1; wdat = DIVISOR[15:8];         end
            OP_LCR:      begin idx = REG_LCR; wr = 1'b1; wdat = {1'b0, LCR_CFG[6:0]};  end
            OP_FCR:      begin idx = REG_FCR; wr = 1'b1; wdat = 8'h06;                 end
            OP_RBR:      begin idx = REG_RBR; wr = 1'b0;                               end
            OP_THR:      begin idx = REG_RBR; wr = 1'b1; wdat = tx_data_i;             end
            default:     begin idx = REG_LSR; wr = 1'b0;                               end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PADDR       <= '0;
            PWDATA      <= '0;
            PWRITE      <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rx_data_o   <= 8'h00;
            rx_perr_o   <= 1'b0;
            rx_valid_o  <= 1'b0;
            init_done_o <= 1'b0;
            apb_err_o   <= 1'b0;
            op          <= OP_LCR_DLAB;
            next_op     <= OP_LCR_DLAB;
            lsr_perr    <= 1'b0;
        end else begin
            if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
            if (!PSEL) begin
                PSEL   <= 1'b1;
                PADDR  <= APB_ADDR_WIDTH'(idx);
                PWRITE <= wr;
                PWDATA <= {24'h000000, wdat};
                op     <= next_op;
            end else if (!PENABLE) begin
                PENABLE <= 1'b1;
            end else if (PREADY) begin
                PSEL    <= 1'b0;
                PENABLE <= 1'b0;
                if (PSLVERR) begin
                    apb_err_o <= 1'b1;
                end
                case (op)
                    OP_LCR_DLAB, OP_DLL, OP_DLM, OP_LCR: begin
                        next_op <= op + 3'd1;
                    end
                    OP_FCR: begin
                        next_op     <= OP_LSR;
                        init_done_o <= 1'b1;
                    end
                    OP_LSR: begin
                        lsr_perr <= PRDATA[2];
                        // A held RX byte blocks further RBR reads; RX wins over TX.
                        if (PRDATA[0] && !rx_valid_o) begin
                            next_op <= OP_RBR;
                        end else if (PRDATA[5] && tx_valid_i) begin
                            next_op <= OP_THR;
                        end else begin
                            next_op <= OP_LSR;
                        end
                    end
                    OP_RBR: begin
                        rx_data_o  <= PRDATA[7:0];
                        rx_perr_o  <= lsr_perr;
                        rx_valid_o <= 1'b1;
                        next_op    <= OP_LSR;
                    end
                    default: begin
                        next_op <= OP_LSR;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apb_uart_host.sv
// Bench for apb_uart_host: APB slave responder plus a rule-level model of the poll/transfer sequence.
module tb_apb_uart_host;

    logic        CLK = 1'b0;
    logic        RST;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE, PSEL, PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [7:0]  tx_data_i;
    logic        tx_valid_i, tx_ready_o;
    logic [7:0]  rx_data_o;
    logic        rx_perr_o, rx_valid_o, rx_ready_i, init_done_o, apb_err_o;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: next expected transfer kind (0 LSR read, 1 RBR read, 2 THR write).
    int         exp_op;
    logic       held, tx_pend, err_seen, m_perr;
    logic [7:0] m_data, tx_byte, lsr_seen, lsr_val, rbr_val;

    apb_uart_host dut (
        .CLK(CLK), .RST(RST), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_perr_o(rx_perr_o), .rx_valid_o(rx_valid_o),
        .rx_ready_i(rx_ready_i), .init_done_o(init_done_o), .apb_err_o(apb_err_o)
    );

    initial forever #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk(tag, 32'({PSEL, PENABLE, PWRITE, tx_ready_o, rx_valid_o, rx_perr_o, init_done_o, apb_err_o}), 0);
        chk(tag, 32'(PADDR), 0);
        chk(tag, PWDATA, 0);
        chk(tag, 32'(rx_data_o), 0);
    endtask

    // Serve one APB transfer; stall = ACCESS cycles with PREADY low before completion.
    task automatic xfer(input int stall, input logic err, input logic exp_thr,
                        output logic [2:0] a, output logic w, output logic [7:0] d, output int gap);
        int cyc = 0;
        a = 3'd7; w = 1'b0; d = 8'h00;
        @(negedge CLK);
        while (!(PSEL === 1'b1 && PENABLE === 1'b0) && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        gap = cyc;
        if (cyc >= 20) begin
            chk("setup_timeout", 32'(cyc), 0);
            return;
        end
        a = PADDR[2:0]; w = PWRITE; d = PWDATA[7:0];
        chk("addr_data_upper", {PADDR[11:3], PWDATA[31:8]}, 0);
        chk("tx_ready_setup", 32'(tx_ready_o), 0);
        PRDATA = {24'h0, (a == 3'd5) ? lsr_val : ((a == 3'd0) ? rbr_val : 8'h00)};
        PREADY = 1'b0; PSLVERR = 1'b0; rx_ready_i = 1'b0;
        @(negedge CLK);
        repeat (stall) begin
            chk("stall_hold", 32'({PSEL, PENABLE, PWRITE, PADDR[2:0], PWDATA[7:0], tx_ready_o}),
                32'({2'b11, w, a, d, 1'b0}));
            @(negedge CLK);
        end
        chk("access", 32'({PSEL, PENABLE, PWRITE, PADDR[2:0], PWDATA[7:0]}), 32'({2'b11, w, a, d}));
        PREADY = 1'b1; PSLVERR = err;
        #1;
        chk("tx_ready", 32'(tx_ready_o), 32'(exp_thr));
        @(negedge CLK);
        PSLVERR = 1'b0;
        chk("idle", 32'({PSEL, PENABLE, tx_ready_o}), 0);
    endtask

    task automatic run_init(input int n);
        logic [10:0] seq [5];
        logic [2:0]  a;
        logic        w;
        logic [7:0]  d;
        int          gap;
        seq[0] = {3'd3, 8'h80};
        seq[1] = {3'd0, 8'h1B};
        seq[2] = {3'd1, 8'h00};
        seq[3] = {3'd3, 8'h03};
        seq[4] = {3'd2, 8'h06};
        for (int i = 0; i < n; i++) begin
            chk("init_done_early", 32'(init_done_o), 0);
            xfer(0, 1'b0, 1'b0, a, w, d, gap);
            chk("init_gap", 32'(gap), 0);
            chk("init_wr", 32'({a, w, d}), 32'({seq[i][10:8], 1'b1, seq[i][7:0]}));
        end
        if (n == 5) chk("init_done", 32'(init_done_o), 1);
    endtask

    task automatic step(input int stall, input logic err);
        logic [2:0] a;
        logic       w;
        logic [7:0] d;
        int         gap;
        xfer(stall, err, exp_op == 2, a, w, d, gap);
        chk("poll_gap", 32'(gap), 0);
        err_seen = err_seen | err;
        case (exp_op)
            0: begin
                chk("lsr_read", 32'({a, w}), 32'({3'd5, 1'b0}));
                lsr_seen = lsr_val;
                if (lsr_seen[0] && !held)        exp_op = 1;
                else if (lsr_seen[5] && tx_pend) exp_op = 2;
                else                             exp_op = 0;
            end
            1: begin
                chk("rbr_read", 32'({a, w}), 32'({3'd0, 1'b0}));
                held = 1'b1; m_data = rbr_val; m_perr = lsr_seen[2];
                exp_op = 0;
            end
            default: begin
                chk("thr_write", 32'({a, w, d}), 32'({3'd0, 1'b1, tx_byte}));
                tx_pend = 1'b0; tx_valid_i = 1'b0;
                exp_op = 0;
            end
        endcase
        chk("rx_valid", 32'(rx_valid_o), 32'(held));
        if (held) chk("rx_byte", 32'({rx_perr_o, rx_data_o}), 32'({m_perr, m_data}));
        chk("apb_err", 32'(apb_err_o), 32'(err_seen));
    endtask

    task automatic offer(input logic [7:0] b);
        tx_valid_i = 1'b1; tx_data_i = b; tx_byte = b; tx_pend = 1'b1;
    endtask

    task automatic consume();
        chk("consume", 32'({rx_valid_o, rx_perr_o, rx_data_o}), 32'({1'b1, m_perr, m_data}));
        rx_ready_i = 1'b1;
        held = 1'b0;
    endtask

    initial begin
        RST = 1'b1; PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = '0;
        tx_valid_i = 1'b0; tx_data_i = 8'h00; rx_ready_i = 1'b0;
        lsr_val = 8'h00; rbr_val = 8'h00; lsr_seen = 8'h00;
        exp_op = 0; held = 1'b0; tx_pend = 1'b0; err_seen = 1'b0; m_perr = 1'b0;
        m_data = 8'h00; tx_byte = 8'h00;
        repeat (3) @(negedge CLK);
        chk_reset("reset_state");
        RST = 1'b0;
        run_init(5);

        // TX only: LSR shows THRE.
        offer(8'h41); lsr_val = 8'h60;
        step(0, 1'b0); step(0, 1'b0);

        // RX held without downstream ready; no further RBR reads.
        lsr_val = 8'h61; rbr_val = 8'h5A;
        step(0, 1'b0); step(0, 1'b0);
        step(0, 1'b0); step(0, 1'b0);
        consume(); rbr_val = 8'h33;
        step(0, 1'b0); step(0, 1'b0);
        consume();

        // RX before TX when both are ready.
        offer(8'h9C); lsr_val = 8'h65; rbr_val = 8'hE7;
        step(0, 1'b0); step(0, 1'b0); step(0, 1'b0); step(0, 1'b0);
        consume();

        // Long stall with slave error; error flag persists.
        lsr_val = 8'h00;
        step(5, 1'b1); step(0, 1'b0); step(2, 1'b0);

        for (int i = 0; i < 60; i++) begin
            if (exp_op == 0) begin
                lsr_val = 8'($urandom_range(0, 255));
                rbr_val = 8'($urandom);
            end
            if (!tx_pend && $urandom_range(0, 1) == 1) offer(8'($urandom));
            if (held && $urandom_range(0, 2) == 0) consume();
            step(int'($urandom_range(0, 2)), $urandom_range(0, 15) == 0);
        end

        // Reset during DLM write ACCESS abandons it and restarts init.
        tx_valid_i = 1'b0; rx_ready_i = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk_reset("reset_again");
        RST = 1'b0;
        run_init(2);
        @(negedge CLK);
        chk("dlm_setup", 32'({PSEL, PENABLE, PADDR[2:0], PWDATA[7:0]}), 32'({2'b10, 3'd1, 8'h00}));
        PREADY = 1'b0;
        @(negedge CLK);
        chk("dlm_access", 32'({PSEL, PENABLE}), 32'(2'b11));
        #2 RST = 1'b1;
        #1 chk_reset("reset_mid_xfer");
        @(negedge CLK);
        RST = 1'b0; PREADY = 1'b1;
        held = 1'b0; err_seen = 1'b0; exp_op = 0;
        offer(8'hC3);
        run_init(5);
        lsr_val = 8'h20;
        step(0, 1'b0); step(0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
